// File: rtl/rx_e1_pkg.sv
// Shared constants, word type and group-count helper for the receive E1 byte packer.
package rx_e1_pkg;
   localparam int E1_SLOTS = 14;
   localparam int MF_LEN   = 16;
   localparam int MFI_W    = $clog2(MF_LEN);
   localparam int CH_W     = 6;

   typedef struct packed {
      logic [CH_W-1:0] ch;
      logic [7:0]      dat_byte;
   } e1_word_t;

   function automatic int gn(input int ch_n);
      return (ch_n + E1_SLOTS - 1) / E1_SLOTS;
   endfunction
endpackage

// File: rtl/rx_e1_byte_pack_if.sv
// Output word stream of the receive E1 byte packer.
// A word moves on every clock edge where Out_Vld and Out_Rdy are both high; while
// Out_Vld is high and Out_Rdy low the source holds Out_Ch/Out_Byte unchanged.
interface rx_e1_byte_pack_if;
   import rx_e1_pkg::*;
   logic            Out_Vld;
   logic            Out_Rdy;
   logic [CH_W-1:0] Out_Ch;
   logic [7:0]      Out_Byte;

   modport master (output Out_Vld, Out_Ch, Out_Byte, input Out_Rdy);
   modport slave  (input Out_Vld, Out_Ch, Out_Byte, output Out_Rdy);
endinterface

// File: rtl/rx_e1_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; read data reads as zero while empty.
module rx_e1_sync_fifo #(
   parameter int W  = 14,
   parameter int AW = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);
   logic [W-1:0]  mem_q [2**AW];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_wr, do_rd;

   assign full    = cnt_q[AW];
   assign empty   = (cnt_q == '0);
   assign rd_data = empty ? '0 : mem_q[rp_q];

   // A write into a full FIFO is accepted when the same edge also pops a word.
   always_comb begin
      do_rd = rd_en & ~empty;
      do_wr = wr_en & (~full | do_rd);
      wp_d  = wp_q + AW'(do_wr);
      rp_d  = rp_q + AW'(do_rd);
      cnt_d = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wp_q] <= wr_data;
   end
endmodule

// File: rtl/rx_e1_byte_pack.sv
// Receive E1 byte packer: per-channel serial-to-byte packers, holding bank, round-robin
// scanner into an output FIFO. Overrun flags are built only with RX_E1_BYTE_PACK_OVR_EN.
module rx_e1_byte_pack
   import rx_e1_pkg::*;
#(
   parameter int CH_N    = 42,
   parameter int FIFO_AW = 4
) (
   input  logic             Ck,
   input  logic             Rs,
   input  logic [MFI_W-1:0] E1_MFI,
   input  logic [5:0]       Dv_Dat,
   input  logic [CH_N-1:0]  Ch_En,
   rx_e1_byte_pack_if.master out_if,
   output logic [CH_N-1:0]  Ovr_Flag,
   input  logic             Ovr_Clr
);
   localparam int GN = gn(CH_N);

   logic [2*GN-1:0] grp;
   logic [CH_N-1:0] hit, dat, done, take, full_q, full_d;
   logic [2:0]      cnt_q  [CH_N];
   logic [2:0]      cnt_d  [CH_N];
   logic [6:0]      sh_q   [CH_N];
   logic [6:0]      sh_d   [CH_N];
   logic [7:0]      hold_q [CH_N];
   logic [7:0]      hold_d [CH_N];
   logic [CH_W-1:0] ptr_q, ptr_d;
   logic            sel_full, fifo_full, fifo_empty, fifo_wr;
   logic [7:0]      sel_hold;
   e1_word_t        wr_word, rd_word;

   assign grp = Dv_Dat[2*GN-1:0];

   // Slot m of group g feeds channel 14g+m; slots 14/15 never match any channel.
   always_comb begin
      hit  = '0;
      dat  = '0;
      done = '0;
      for (int c = 0; c < CH_N; c++) begin
         hit[c]    = (E1_MFI == MFI_W'(c % E1_SLOTS)) && grp[2*(c / E1_SLOTS) + 1];
         dat[c]    = grp[2*(c / E1_SLOTS)];
         cnt_d[c]  = cnt_q[c];
         sh_d[c]   = sh_q[c];
         hold_d[c] = hold_q[c];
         if (!Ch_En[c]) begin
            cnt_d[c] = '0;
            sh_d[c]  = '0;
         end else if (hit[c]) begin
            sh_d[c]  = {sh_q[c][5:0], dat[c]};
            cnt_d[c] = cnt_q[c] + 3'd1;
            if (cnt_q[c] == 3'd7) begin
               hold_d[c] = {sh_q[c], dat[c]};
               done[c]   = 1'b1;
            end
         end
      end
   end

   // Scanner stalls only on a full slot it cannot push; a fresh byte beats the scan clear.
   always_comb begin
      sel_full = 1'b0;
      sel_hold = '0;
      take     = '0;
      full_d   = full_q;
      for (int c = 0; c < CH_N; c++) begin
         if (ptr_q == CH_W'(c)) begin
            sel_full = full_q[c];
            sel_hold = hold_q[c];
         end
         take[c] = full_q[c] && (ptr_q == CH_W'(c)) && !fifo_full;
         if (!Ch_En[c])    full_d[c] = 1'b0;
         else if (done[c]) full_d[c] = 1'b1;
         else if (take[c]) full_d[c] = 1'b0;
      end
      fifo_full_stall:
      begin
         fifo_wr          = sel_full && !fifo_full;
         wr_word.ch       = ptr_q;
         wr_word.dat_byte = sel_hold;
         if (sel_full && fifo_full)          ptr_d = ptr_q;
         else if (ptr_q == CH_W'(CH_N - 1))  ptr_d = '0;
         else                                ptr_d = ptr_q + 1'b1;
      end
   end

   always_ff @(posedge Ck or posedge Rs) begin
      if (Rs) begin
         for (int c = 0; c < CH_N; c++) begin
            cnt_q[c]  <= '0;
            sh_q[c]   <= '0;
            hold_q[c] <= '0;
         end
         full_q <= '0;
         ptr_q  <= '0;
      end else begin
         for (int c = 0; c < CH_N; c++) begin
            cnt_q[c]  <= cnt_d[c];
            sh_q[c]   <= sh_d[c];
            hold_q[c] <= hold_d[c];
         end
         full_q <= full_d;
         ptr_q  <= ptr_d;
      end
   end

`ifdef RX_E1_BYTE_PACK_OVR_EN
   logic [CH_N-1:0] ovr_q, ovr_d;

   // Clear and a same-cycle overrun: the overrun wins.
   always_comb ovr_d = (ovr_q & ~{CH_N{Ovr_Clr}}) | (done & full_q & ~take);

   always_ff @(posedge Ck or posedge Rs) begin
      if (Rs) ovr_q <= '0;
      else    ovr_q <= ovr_d;
   end

   assign Ovr_Flag = ovr_q;
`else
   logic ovr_clr_unused;
   assign ovr_clr_unused = Ovr_Clr;
   assign Ovr_Flag       = '0;
`endif

   rx_e1_sync_fifo #(
      .W  ($bits(e1_word_t)),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk     (Ck),
      .rst     (Rs),
      .wr_en   (fifo_wr),
      .wr_data (wr_word),
      .rd_en   (out_if.Out_Rdy),
      .rd_data (rd_word),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign out_if.Out_Vld  = ~fifo_empty;
   assign out_if.Out_Ch   = rd_word.ch;
   assign out_if.Out_Byte = rd_word.dat_byte;
endmodule

// File: tb/tb_rx_e1_byte_pack.sv
// Bench for rx_e1_byte_pack: per-channel bit-collecting reference model feeding a word scoreboard.
module tb_rx_e1_byte_pack;
   localparam int CH_N = 42;
`ifdef RX_E1_BYTE_PACK_OVR_EN
   localparam bit OVR_BUILT = 1'b1;
`else
   localparam bit OVR_BUILT = 1'b0;
`endif

   logic            Ck = 1'b0;
   logic            Rs;
   logic [3:0]      E1_MFI;
   logic [5:0]      Dv_Dat;
   logic [CH_N-1:0] Ch_En;
   logic [CH_N-1:0] Ovr_Flag;
   logic            Ovr_Clr;

   rx_e1_byte_pack_if out_if();

   rx_e1_byte_pack #(.CH_N(CH_N), .FIFO_AW(4)) dut (
      .Ck       (Ck),
      .Rs       (Rs),
      .E1_MFI   (E1_MFI),
      .Dv_Dat   (Dv_Dat),
      .Ch_En    (Ch_En),
      .out_if   (out_if),
      .Ovr_Flag (Ovr_Flag),
      .Ovr_Clr  (Ovr_Clr)
   );

   always #5 Ck = ~Ck;

   int              n_checks = 0;
   int              n_fail   = 0;
   int              n_words  = 0;
   logic [13:0]     exp_q[$];
   int              m_n   [CH_N];
   logic [7:0]      m_acc [CH_N];
   logic            rdy_rand = 1'b0;
   logic            rdy_fix  = 1'b1;
   logic [7:0]      tx_b  [CH_N];
   logic [CH_N-1:0] mask;

   // ---------------- driver tasks ----------------
   task automatic drive_cycle(input logic [3:0] mfi, input logic [5:0] dd, input logic clr);
      @(posedge Ck);
      #1;
      E1_MFI         = mfi;
      Dv_Dat         = dd;
      Ovr_Clr        = clr;
      out_if.Out_Rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(4'd0, 6'd0, 1'b0);
   endtask

   task automatic set_en(input logic [CH_N-1:0] v);
      drive_cycle(4'd0, 6'd0, 1'b0);
      Ch_En = v;
      for (int c = 0; c < CH_N; c++) if (!v[c]) m_n[c] = 0;
   endtask

   task automatic clear_model();
      exp_q.delete();
      for (int c = 0; c < CH_N; c++) begin
         m_n[c]   = 0;
         m_acc[c] = '0;
      end
   endtask

   // Sends bits 7 downward of each masked channel's byte, one bit per multiframe.
   task automatic send(input int nbits, input bit noise, input int clr_ch, input int last_slot);
      for (int b = 0; b < nbits; b++) begin
         for (int s = 0; s < 16; s++) begin
            logic [5:0] dd;
            logic       clr;
            int         c;
            logic       bt;
            if (b == nbits - 1 && s > last_slot) break;
            dd  = '0;
            clr = 1'b0;
            for (int g = 0; g < 3; g++) begin
               c = 14*g + s;
               if (s >= 14) begin
                  if (noise) begin
                     dd[2*g+1] = 1'b1;
                     dd[2*g]   = 1'($urandom_range(0, 1));
                  end
               end else if (c < CH_N && mask[c]) begin
                  bt        = tx_b[c][7-b];
                  dd[2*g+1] = 1'b1;
                  dd[2*g]   = bt;
                  if (Ch_En[c]) begin
                     m_acc[c] = {m_acc[c][6:0], bt};
                     m_n[c]   = m_n[c] + 1;
                     if (m_n[c] == 8) begin
                        exp_q.push_back({6'(c), m_acc[c]});
                        m_n[c] = 0;
                        if (c == clr_ch) clr = 1'b1;
                     end
                  end else begin
                     m_n[c] = 0;
                  end
               end
            end
            drive_cycle(4'(s), dd, clr);
         end
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) idle(1);
      idle(60);
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge Ck) begin
      int idx;
      if (Rs === 1'b0 && out_if.Out_Vld === 1'b1 && out_if.Out_Rdy === 1'b1) begin
         idx     = -1;
         n_words = n_words + 1;
         for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i][13:8] == out_if.Out_Ch) begin
               idx = i;
               break;
            end
         end
         n_checks = n_checks + 1;
         if (idx < 0) begin
            n_fail = n_fail + 1;
            $display("FAIL unexpected_word: got ch=%0d byte=%02h, required no word for that channel",
                     out_if.Out_Ch, out_if.Out_Byte);
         end else begin
            if (exp_q[idx][7:0] !== out_if.Out_Byte) begin
               n_fail = n_fail + 1;
               $display("FAIL word_byte ch=%0d: got %02h, required %02h",
                        out_if.Out_Ch, out_if.Out_Byte, exp_q[idx][7:0]);
            end
            exp_q.delete(idx);
         end
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      Rs = 1'b1; E1_MFI = '0; Dv_Dat = '0; Ch_En = '1; Ovr_Clr = 1'b0; out_if.Out_Rdy = 1'b1;
      clear_model();
      repeat (3) @(posedge Ck);
      @(negedge Ck);
      n_checks = n_checks + 4;
      if (out_if.Out_Vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b, required 0", out_if.Out_Vld); end
      if (out_if.Out_Ch !== 6'd0) begin n_fail++; $display("FAIL reset_ch: got %0d, required 0", out_if.Out_Ch); end
      if (out_if.Out_Byte !== 8'd0) begin n_fail++; $display("FAIL reset_byte: got %02h, required 00", out_if.Out_Byte); end
      if (Ovr_Flag !== '0) begin n_fail++; $display("FAIL reset_ovr: got %h, required 0", Ovr_Flag); end
      @(posedge Ck); #1;
      Rs = 1'b0;
   endtask

   task automatic test_single_byte();
      int lat;
      logic [5:0] ch_s;
      logic [7:0] byte_s;
      rdy_fix = 1'b1; n_words = 0; lat = -1; ch_s = '0; byte_s = '0;
      for (int c = 0; c < CH_N; c++) tx_b[c] = 8'h00;
      tx_b[0] = 8'hA5;
      mask = '0; mask[0] = 1'b1;
      send(8, 1'b0, -1, 0);
      idle(1);
      @(negedge Ck);
      n_checks++;
      if (out_if.Out_Vld !== 1'b0) begin n_fail++; $display("FAIL single_early_vld: got %b one cycle after 8th sample, required 0", out_if.Out_Vld); end
      for (int k = 1; k <= CH_N; k++) begin
         idle(1);
         @(negedge Ck);
         if (out_if.Out_Vld === 1'b1) begin
            lat = k + 1; ch_s = out_if.Out_Ch; byte_s = out_if.Out_Byte;
            break;
         end
      end
      n_checks = n_checks + 3;
      if (lat < 2 || lat > CH_N + 1) begin n_fail++; $display("FAIL single_latency: got %0d cycles, required 2..%0d", lat, CH_N + 1); end
      if (ch_s !== 6'd0) begin n_fail++; $display("FAIL single_ch: got %0d, required 0", ch_s); end
      if (byte_s !== 8'hA5) begin n_fail++; $display("FAIL single_byte: got %02h, required a5", byte_s); end
      wait_drain();
      n_checks++;
      if (n_words !== 1 || exp_q.size() !== 0) begin n_fail++; $display("FAIL single_count: got %0d words (%0d pending), required 1 (0)", n_words, exp_q.size()); end
   endtask

   task automatic test_all_channels();
      rdy_fix = 1'b1; n_words = 0;
      for (int c = 0; c < CH_N; c++) tx_b[c] = 8'h3C;
      mask = '1;
      send(8, 1'b0, -1, 15);
      wait_drain();
      n_checks = n_checks + 2;
      if (n_words !== CH_N || exp_q.size() !== 0) begin n_fail++; $display("FAIL all_count: got %0d words (%0d pending), required %0d (0)", n_words, exp_q.size(), CH_N); end
      if (Ovr_Flag !== '0) begin n_fail++; $display("FAIL all_ovr: got %h, required 0", Ovr_Flag); end
   endtask

   task automatic test_random();
      rdy_rand = 1'b1;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < CH_N; c++) tx_b[c] = 8'($urandom);
         mask = CH_N'({$urandom(), $urandom()});
         mask[$urandom_range(0, CH_N - 1)] = 1'b1;
         send(8, 1'($urandom_range(0, 1)), -1, 15);
         wait_drain();
         n_checks++;
         if (exp_q.size() !== 0) begin n_fail++; $display("FAIL random_drain round %0d: got %0d pending, required 0", r, exp_q.size()); end
      end
      rdy_rand = 1'b0;
   endtask

   task automatic test_ignored_disabled();
      logic [CH_N-1:0] en;
      rdy_fix = 1'b1; n_words = 0;
      en = '1; en[27] = 1'b0;
      set_en(en);
      for (int c = 0; c < CH_N; c++) tx_b[c] = 8'($urandom);
      mask = '0; mask[27] = 1'b1;
      send(8, 1'b1, -1, 15);
      send(5, 1'b1, -1, 15);
      idle(100);
      n_checks++;
      if (n_words !== 0) begin n_fail++; $display("FAIL ignored_words: got %0d words, required 0", n_words); end
      set_en('1);
      tx_b[27] = 8'h5A;
      send(8, 1'b1, -1, 15);
      tx_b[27] = 8'hF0;
      send(3, 1'b0, -1, 15);
      set_en(en);
      idle(3);
      set_en('1);
      tx_b[27] = 8'hC3;
      send(8, 1'b0, -1, 15);
      wait_drain();
      n_checks++;
      if (n_words !== 2 || exp_q.size() !== 0) begin n_fail++; $display("FAIL reenable_count: got %0d words (%0d pending), required 2 (0)", n_words, exp_q.size()); end
   endtask

   task automatic test_backpressure_overrun();
      logic [5:0]      hold_ch;
      logic [7:0]      hold_byte;
      logic [CH_N-1:0] ovr_e;
      rdy_fix = 1'b0; n_words = 0;
      for (int c = 0; c < CH_N; c++) tx_b[c] = 8'($urandom);
      mask = '1; mask[15] = 1'b0;
      send(8, 1'b0, -1, 15);
      idle(10);
      @(negedge Ck);
      hold_ch = out_if.Out_Ch; hold_byte = out_if.Out_Byte;
      n_checks++;
      if (out_if.Out_Vld !== 1'b1) begin n_fail++; $display("FAIL bp_vld: got %b, required 1", out_if.Out_Vld); end
      mask = '0; mask[15] = 1'b1;
      tx_b[15] = 8'h11;
      send(8, 1'b0, -1, 15);
      idle(5);
      @(negedge Ck);
      n_checks++;
      if (Ovr_Flag[15] !== 1'b0) begin n_fail++; $display("FAIL bp_no_ovr_yet: got %b, required 0", Ovr_Flag[15]); end
      tx_b[15] = 8'h22;
      send(8, 1'b0, 15, 15);
      idle(2);
      @(negedge Ck);
      ovr_e = '0; ovr_e[15] = OVR_BUILT;
      n_checks = n_checks + 2;
      if (Ovr_Flag !== ovr_e) begin n_fail++; $display("FAIL bp_ovr_set_wins: got %h, required %h", Ovr_Flag, ovr_e); end
      if (out_if.Out_Vld !== 1'b1 || out_if.Out_Ch !== hold_ch || out_if.Out_Byte !== hold_byte) begin
         n_fail++;
         $display("FAIL bp_stable: got vld=%b ch=%0d byte=%02h, required vld=1 ch=%0d byte=%02h",
                  out_if.Out_Vld, out_if.Out_Ch, out_if.Out_Byte, hold_ch, hold_byte);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i] == {6'd15, 8'h11}) begin
            exp_q.delete(i);
            break;
         end
      end
      drive_cycle(4'd0, 6'd0, 1'b1);
      idle(1);
      @(negedge Ck);
      n_checks++;
      if (Ovr_Flag !== '0) begin n_fail++; $display("FAIL ovr_clear: got %h, required 0", Ovr_Flag); end
      rdy_fix = 1'b1;
      wait_drain();
      n_checks++;
      if (n_words !== CH_N || exp_q.size() !== 0) begin n_fail++; $display("FAIL bp_drain: got %0d words (%0d pending), required %0d (0)", n_words, exp_q.size(), CH_N); end
   endtask

   task automatic test_reset_midstream();
      rdy_fix = 1'b0; n_words = 0;
      for (int c = 0; c < CH_N; c++) tx_b[c] = 8'($urandom);
      mask = '0; mask[1] = 1'b1; mask[2] = 1'b1; mask[3] = 1'b1;
      send(8, 1'b0, -1, 15);
      mask = '0; mask[5] = 1'b1;
      send(4, 1'b0, -1, 15);
      idle(50);
      @(negedge Ck);
      n_checks++;
      if (out_if.Out_Vld !== 1'b1) begin n_fail++; $display("FAIL midrst_queued: got %b, required 1", out_if.Out_Vld); end
      @(posedge Ck); #1;
      Rs = 1'b1;
      #1;
      n_checks++;
      if (out_if.Out_Vld !== 1'b0) begin n_fail++; $display("FAIL midrst_vld: got %b, required 0", out_if.Out_Vld); end
      clear_model();
      idle(3);
      Rs = 1'b0;
      rdy_fix = 1'b1;
      idle(100);
      send(4, 1'b0, -1, 15);
      idle(100);
      n_checks = n_checks + 2;
      if (n_words !== 0) begin n_fail++; $display("FAIL midrst_words: got %0d words, required 0", n_words); end
      if (Ovr_Flag !== '0) begin n_fail++; $display("FAIL midrst_ovr: got %h, required 0", Ovr_Flag); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_all_channels();
      test_random();
      test_ignored_disabled();
      test_backpressure_overrun();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
